risc_mem_arbiter: RTL and testbench

- Shares the single-port program/data memory between NREQ requesters, e.g. the CPU fetch/execute path and a loader/debug port.
- Sits between the requesters and the memory's wr/rd/addr/data pins.
- Round-robin arbitration, one access per grant, optional locked bursts.
- Latches each request at grant and drives the memory strobes from registers.

---
 rtl/risc_mem_arbiter_pkg.sv | 17 +
 rtl/risc_mem_arbiter_if.sv | 35 +++
 rtl/risc_mem_arbiter_rr_pick.sv | 28 ++
 rtl/risc_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_risc_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_mem_arbiter_pkg.sv
// Shared types and helpers for the risc_mem_arbiter block (package risc_arb_pkg).
package risc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

    localparam int DEF_AWIDTH = 5;
    localparam int DEF_DWIDTH = 8;

    function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter, master = requesters/memory.
interface risc_mem_arbiter_if
    import risc_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        we;
    logic [NREQ*AWIDTH-1:0] addr;
    logic [NREQ*DWIDTH-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [DWIDTH-1:0]      rdata;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [AWIDTH-1:0]      mem_addr;
    logic [DWIDTH-1:0]      mem_wdata;
    logic [DWIDTH-1:0]      mem_rdata;
    logic                   busy;
    logic                   lock_timeout;

    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy, lock_timeout
    );

    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy, lock_timeout
    );

endinterface

// File: rtl/risc_mem_arbiter_rr_pick.sv
// Combinational round-robin winner search starting at rr_ptr_i.
module arb_rr_pick
    import risc_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_ptr_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        int unsigned cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 32'(rr_ptr_i);
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[IDXW'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IDXW'(cand);
            end
            cand = idx_inc(cand, NREQ);
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Round-robin single-port memory arbiter with optional locked bursts.
// Optional lock timeout: define ARB_LOCK_TIMEOUT_EN (bounds a lock to MAX_LOCK accesses).
module risc_mem_arbiter
    import risc_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    risc_mem_arbiter_if.slave    bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d, rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   pick_idx, sel_idx;
    logic              pick_valid, lock_hit;
    logic              we_q, we_d, sel_we;
    logic [AWIDTH-1:0] addr_q, addr_d, sel_addr, mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d, sel_wdata, mem_wdata_q, mem_wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d, lock_to_q, lock_to_d;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

    // New winner in IDLE, current owner when re-latching a locked burst.
    assign sel_idx   = (state_q == IDLE) ? pick_idx : idx_q;
    assign sel_we    = bus.we[sel_idx];
    assign sel_addr  = bus.addr[sel_idx*AWIDTH +: AWIDTH];
    assign sel_wdata = bus.wdata[sel_idx*DWIDTH +: DWIDTH];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        lock_hit    = 1'b0;
        lock_to_d   = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
        lock_cnt_d  = lock_cnt_q;
`endif
        // Strobes, ack and busy form a register stage that trails the FSM by one cycle.
        mem_rd_d    = (state_q == ACCESS) && !we_q;
        mem_wr_d    = (state_q == ACCESS) && we_q;
        mem_addr_d  = (state_q == ACCESS) ? addr_q  : mem_addr_q;
        mem_wdata_d = (state_q == ACCESS) ? wdata_q : mem_wdata_q;
        rdata_d     = mem_rd_q ? bus.mem_rdata : rdata_q;
        busy_d      = (state_q != IDLE);
        ack_d       = '0;
        if (state_q == ACK) ack_d[idx_q] = 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d          = pick_idx;
                    we_d           = sel_we;
                    addr_d         = sel_addr;
                    wdata_d        = sel_wdata;
                    gnt_d          = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d        = ACCESS;
                end
            end
            ACCESS: state_d = ACK;
            ACK: begin
                lock_hit = bus.lock[idx_q] & bus.req[idx_q];
`ifdef ARB_LOCK_TIMEOUT_EN
                if (lock_hit && lock_cnt_q == LCW'(MAX_LOCK - 1)) begin
                    lock_hit  = 1'b0;
                    lock_to_d = 1'b1;
                end
`endif
                if (lock_hit) begin
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ACCESS;
`ifdef ARB_LOCK_TIMEOUT_EN
                    lock_cnt_d = LCW'(lock_cnt_q + 1'b1);
`endif
                end else begin
                    gnt_d    = '0;
                    rr_ptr_d = IDXW'(idx_inc(32'(idx_q), NREQ));
                    state_d  = IDLE;
`ifdef ARB_LOCK_TIMEOUT_EN
                    lock_cnt_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            lock_to_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            lock_to_q   <= lock_to_d;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_cnt_q <= '0;
        else     lock_cnt_q <= lock_cnt_d;
    end
    assign bus.lock_timeout = lock_to_q;
`else
    assign bus.lock_timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter (NREQ=2); also builds with ARB_LOCK_TIMEOUT_EN (MAX_LOCK=2).
module tb_risc_mem_arbiter;
    import risc_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 8;
`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int   MAX_LOCK = 2;
    localparam int   NLOCK    = 2;
    localparam logic EXP_TO   = 1'b1;
`else
    localparam int   MAX_LOCK = 4;
    localparam int   NLOCK    = 6;
    localparam logic EXP_TO   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_mem_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    risc_mem_arbiter #(
        .NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: combinational read, write on the edge closing a mem_wr cycle.
    logic [DW-1:0] mem [32] = '{3: 8'hA5, default: 8'h00};
    assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : '0;
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

    typedef struct { int idx; bit rd; logic [DW-1:0] data; } ack_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;

    ack_exp_t ack_q [$];
    wr_exp_t  wr_q  [$];
    ack_exp_t ae;
    wr_exp_t  we_e;
    logic     prev_wr = 1'b0;
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input int i, input bit rd, input logic [DW-1:0] d);
        ack_exp_t e;
        e.idx = i; e.rd = rd; e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_exp_t e;
        e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic drive(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.we[i]               = w;
        bus.addr[i*AW +: AW]    = a;
        bus.wdata[i*DW +: DW]   = d;
    endtask

    task automatic wait_ack(input int i, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack[i] && n < 20);
        check({name, "_ack_seen"}, 32'(bus.ack[i]), 1);
    endtask

    // Monitor: pops expectations whenever the DUT presents an ack or a write strobe.
    always @(negedge clk) begin
        if (bus.ack != '0) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(bus.ack), 0);
            end else begin
                ae = ack_q.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'(1) << ae.idx);
                if (ae.rd) check("rdata", 32'(bus.rdata), 32'(ae.data));
            end
        end
        if (bus.mem_wr) begin
            check("mem_wr_single_cycle", 32'(prev_wr), 0);
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(bus.mem_wr), 0);
            end else begin
                we_e = wr_q.pop_front();
                check("mem_addr_wr", 32'(bus.mem_addr), 32'(we_e.addr));
                check("mem_wdata", 32'(bus.mem_wdata), 32'(we_e.data));
            end
        end
        prev_wr = bus.mem_wr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, last;
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_gnt",       32'(bus.gnt), 0);
        check("rst_ack",       32'(bus.ack), 0);
        check("rst_rdata",     32'(bus.rdata), 0);
        check("rst_mem_rd",    32'(bus.mem_rd), 0);
        check("rst_mem_wr",    32'(bus.mem_wr), 0);
        check("rst_mem_addr",  32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_lock_to",   32'(bus.lock_timeout), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single read of address 3, cycle by cycle
        push_ack(0, 1'b1, 8'hA5);
        drive(0, 1'b0, 5'h03, 8'h00);
        @(negedge clk);
        check("rd_gnt_c1", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        check("rd_mem_rd_c2", 32'(bus.mem_rd), 1);
        check("rd_mem_addr_c2", 32'(bus.mem_addr), 32'h03);
        @(negedge clk);
        check("rd_ack_c3", 32'(bus.ack), 32'h1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("rd_busy_c4", 32'(bus.busy), 0);

        // Write 1F <- 3C from requester 1, then read it back via requester 0
        push_wr(5'h1F, 8'h3C);
        push_ack(1, 1'b0, 8'h00);
        drive(1, 1'b1, 5'h1F, 8'h3C);
        wait_ack(1, "wr1");
        bus.req[1] = 1'b0;
        push_ack(0, 1'b1, 8'h3C);
        drive(0, 1'b0, 5'h1F, 8'h00);
        wait_ack(0, "rdback");
        bus.req[0] = 1'b0;

        // Contention from reset: both held, expect 0,1,0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_ack(0, 1'b1, 8'hA5);
            else            push_ack(1, 1'b1, 8'h3C);
        end
        drive(0, 1'b0, 5'h03, 8'h00);
        drive(1, 1'b0, 5'h1F, 8'h00);
        rst = 1'b0;
        k = 0; n = 0;
        while (k < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.ack != '0) k++;
        end
        check("fair_ack_count", k, 6);
        bus.req = '0;
        @(negedge clk);

        // Locked burst of writes from requester 0 while requester 1 waits
        for (int i = 0; i < NLOCK; i++) begin
            push_ack(0, 1'b0, 8'h00);
            push_wr(AW'(5'h10 + i), DW'(8'h80 + i));
        end
        push_ack(1, 1'b1, 8'hA5);
        drive(0, 1'b1, 5'h10, 8'h80);
        bus.lock[0] = 1'b1;
        drive(1, 1'b0, 5'h03, 8'h00);
        k = 0; n = 0; last = 0;
        while (k < NLOCK && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.mem_wr) begin
                k++;
                if (k > 1) check("lock_spacing", n - last, 2);
                last = n;
                if (k < NLOCK) begin
                    bus.addr[0 +: AW]  = AW'(5'h10 + k);
                    bus.wdata[0 +: DW] = DW'(8'h80 + k);
                end else if (!EXP_TO) begin
                    bus.lock[0] = 1'b0;
                    bus.req[0]  = 1'b0;
                end
            end
        end
        check("lock_write_count", k, NLOCK);
        @(negedge clk);
        check("lock_timeout_pulse", 32'(bus.lock_timeout), 32'(EXP_TO));
        bus.lock[0] = 1'b0;
        bus.req[0]  = 1'b0;
        @(negedge clk);
        check("lock_timeout_end", 32'(bus.lock_timeout), 0);
        wait_ack(1, "after_lock");
        bus.req[1] = 1'b0;
        @(negedge clk);

        // Reset during the write strobe aborts immediately
        push_wr(5'h02, 8'h77);
        drive(0, 1'b1, 5'h02, 8'h77);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_wr && n < 20);
        check("abort_saw_mem_wr", 32'(bus.mem_wr), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_wr", 32'(bus.mem_wr), 0);
        check("abort_gnt", 32'(bus.gnt), 0);
        check("abort_busy", 32'(bus.busy), 0);
        bus.req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // rr_ptr restarts at 0: simultaneous requests go to 0 first
        push_ack(0, 1'b1, 8'h3C);
        push_ack(1, 1'b1, 8'hA5);
        drive(0, 1'b0, 5'h1F, 8'h00);
        drive(1, 1'b0, 5'h03, 8'h00);
        @(negedge clk);
        check("post_rst_first_gnt", 32'(bus.gnt), 32'h1);
        n = 0;
        while (bus.req != '0 && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.ack[0]) bus.req[0] = 1'b0;
            if (bus.ack[1]) bus.req[1] = 1'b0;
        end
        check("post_rst_both_done", 32'(bus.req), 0);

        // Requester 1 alone is granted normally
        push_ack(1, 1'b1, 8'hA5);
        drive(1, 1'b0, 5'h03, 8'h00);
        @(negedge clk);
        check("req1_only_gnt", 32'(bus.gnt), 32'h2);
        wait_ack(1, "req1_only");
        bus.req[1] = 1'b0;

        repeat (4) @(negedge clk);
        check("ack_queue_empty", ack_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
